// File: rtl/jfpjc_byte_stuffer.sv
// JPEG entropy-coded segment byte stuffer: splits 32-bit packer words into bytes (LSB first),
// inserts 0x00 after each 0xFF and optionally closes the scan with an FFD9 marker.
module jfpjc_byte_stuffer #(
  parameter int unsigned EOI_ENABLE = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        data_in_valid,
  output logic        data_in_ready,
  input  logic        eoi_request,
  output logic        eoi_done,
  output logic [7:0]  byte_out,
  output logic        byte_out_valid,
  input  logic        byte_out_ready,
  output logic [31:0] byte_count
);

  typedef enum logic [2:0] {IDLE, EMIT, STUFF, EOI_FF, EOI_D9} state_t;

  state_t      r_state;
  logic [31:0] r_word;
  logic [1:0]  r_idx;
  logic        r_pending;
  logic        r_ready;
  logic        r_valid;
  logic        r_eoi_done;
  logic [7:0]  r_byte;
  logic [31:0] r_count;

  logic        w_xfer;
  logic        w_pend;
  logic        w_advance;
  logic [1:0]  w_next_idx;
  logic [7:0]  w_next_byte;

  assign w_xfer      = r_valid & byte_out_ready;
  assign w_pend      = r_pending | eoi_request;
  assign w_next_idx  = r_idx + 2'd1;
  assign w_next_byte = r_word[{w_next_idx, 3'b000} +: 8];
  // A data byte that is not 0xFF, or a completed stuff byte, moves on to the next byte slot.
  assign w_advance   = w_xfer && (((r_state == EMIT) && (r_byte != 8'hFF)) || (r_state == STUFF));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_word     <= 32'd0;
      r_idx      <= 2'd0;
      r_pending  <= 1'b0;
      r_ready    <= 1'b0;
      r_valid    <= 1'b0;
      r_eoi_done <= 1'b0;
      r_byte     <= 8'h00;
      r_count    <= 32'd0;
    end else begin
      r_eoi_done <= 1'b0;
      if (r_eoi_done)
        r_count <= 32'd0;
      else if (w_xfer)
        r_count <= r_count + 32'd1;
      if (eoi_request)
        r_pending <= 1'b1;

      case (r_state)
        IDLE: begin
          if (data_in_valid && r_ready) begin
            r_word  <= data_in;
            r_idx   <= 2'd0;
            r_byte  <= data_in[7:0];
            r_valid <= 1'b1;
            r_ready <= 1'b0;
            r_state <= EMIT;
          end else if (w_pend) begin
            if (EOI_ENABLE != 0) begin
              r_state <= EOI_FF;
              r_byte  <= 8'hFF;
              r_valid <= 1'b1;
              r_ready <= 1'b0;
            end else begin
              r_pending  <= 1'b0;
              r_eoi_done <= 1'b1;
              r_ready    <= 1'b1;
            end
          end else begin
            r_ready <= 1'b1;
          end
        end
        EMIT: begin
          if (w_xfer && (r_byte == 8'hFF)) begin
            r_state <= STUFF;
            r_byte  <= 8'h00;
          end
        end
        EOI_FF: begin
          if (w_xfer) begin
            r_state <= EOI_D9;
            r_byte  <= 8'hD9;
          end
        end
        EOI_D9: begin
          if (w_xfer) begin
            r_state    <= IDLE;
            r_valid    <= 1'b0;
            r_pending  <= 1'b0;
            r_eoi_done <= 1'b1;
            r_ready    <= 1'b1;
          end
        end
        default: begin
        end
      endcase

      // After the last byte of a word, go straight to the marker so no idle gap precedes it.
      if (w_advance) begin
        if (r_idx != 2'd3) begin
          r_state <= EMIT;
          r_idx   <= w_next_idx;
          r_byte  <= w_next_byte;
        end else if (w_pend && (EOI_ENABLE != 0)) begin
          r_state <= EOI_FF;
          r_byte  <= 8'hFF;
        end else begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_ready <= !w_pend;
        end
      end
    end
  end

  assign data_in_ready  = r_ready;
  assign eoi_done       = r_eoi_done;
  assign byte_out       = r_byte;
  assign byte_out_valid = r_valid;
  assign byte_count     = r_count;

endmodule

// File: tb/tb_jfpjc_byte_stuffer.sv
// Self-checking bench for jfpjc_byte_stuffer: directed scenarios plus randomized words
// and backpressure compared against a queue-based stuffing model.
module tb_jfpjc_byte_stuffer;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic        data_in_valid;
  logic        data_in_ready;
  logic        eoi_request;
  logic        eoi_done;
  logic [7:0]  byte_out;
  logic        byte_out_valid;
  logic        byte_out_ready;
  logic [31:0] byte_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int eoiDoneCnt = 0;
  bit bpRandom = 1'b0;
  bit prevStall = 1'b0;
  logic [7:0] prevByte = 8'h00;

  logic [7:0] rxq[$];
  int         rxc[$];
  logic [7:0] expq[$];

  jfpjc_byte_stuffer #(.EOI_ENABLE(1)) dut (
    .clock(clock),
    .reset(reset),
    .data_in(data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .eoi_request(eoi_request),
    .eoi_done(eoi_done),
    .byte_out(byte_out),
    .byte_out_valid(byte_out_valid),
    .byte_out_ready(byte_out_ready),
    .byte_count(byte_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    #1;
    if (bpRandom) byte_out_ready = ($urandom_range(0, 3) != 0);
  end

  // Records every transfer and checks that a stalled byte stays put until taken.
  always @(negedge clock) begin
    if (!reset) begin
      if (prevStall) begin
        checks++;
        if (!byte_out_valid || byte_out !== prevByte) begin
          errors++;
          $display("[TB] FAIL hold_stable: got valid=%0b byte=%h, want valid=1 byte=%h",
                   byte_out_valid, byte_out, prevByte);
        end
      end
      if (byte_out_valid && byte_out_ready) begin
        rxq.push_back(byte_out);
        rxc.push_back(cyc);
      end
      if (eoi_done) eoiDoneCnt++;
      prevStall = byte_out_valid && !byte_out_ready;
      prevByte  = byte_out;
    end else begin
      prevStall = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model: each byte in LSB-first order, with a 0x00 following every 0xFF.
  task automatic model_word(input logic [31:0] w, output int nBytes);
    logic [7:0] b;
    nBytes = 0;
    for (int j = 0; j < 4; j++) begin
      b = w[8*j +: 8];
      expq.push_back(b);
      nBytes++;
      if (b == 8'hFF) begin
        expq.push_back(8'h00);
        nBytes++;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    data_in_valid = 1'b0;
    eoi_request = 1'b0;
    byte_out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    rxq.delete();
    rxc.delete();
    expq.delete();
    eoiDoneCnt = 0;
  endtask

  // Returns at 1 time unit after the accepting edge.
  task automatic send_word(input logic [31:0] w, input bit eoi, output int accCyc);
    int n = 0;
    accCyc = -1;
    @(posedge clock);
    #1;
    data_in = w;
    data_in_valid = 1'b1;
    while (!data_in_ready && n < 500) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (!data_in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: data_in_ready=0 after %0d cycles, want 1", n);
      data_in_valid = 1'b0;
      return;
    end
    eoi_request = eoi;
    @(posedge clock);
    #1;
    accCyc = cyc;
    data_in_valid = 1'b0;
    eoi_request = 1'b0;
    data_in = $urandom;
  endtask

  task automatic send_eoi();
    int n = 0;
    @(posedge clock);
    #1;
    while (!data_in_ready && n < 500) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (!data_in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL eoi_timeout: data_in_ready=0 after %0d cycles, want 1", n);
      return;
    end
    eoi_request = 1'b1;
    @(posedge clock);
    #1;
    eoi_request = 1'b0;
  endtask

  task automatic wait_drain(output bit timedOut);
    int n = 0;
    while (rxq.size() < expq.size() && n < 3000) begin
      @(negedge clock);
      n++;
    end
    timedOut = (rxq.size() < expq.size());
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    data_in = 32'd0;
    data_in_valid = 1'b0;
    eoi_request = 1'b0;
    byte_out_ready = 1'b1;
    #1;
    checks++;
    if ({byte_out, byte_out_valid, eoi_done, data_in_ready} !== 11'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got byte=%h valid=%0b done=%0b ready=%0b, want all 0",
               byte_out, byte_out_valid, eoi_done, data_in_ready);
    end
    checks++;
    if (byte_count !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_count: got %0d, want 0", byte_count);
    end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (data_in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_reset: got %0b, want 1", data_in_ready);
    end
  endtask

  task automatic test_basic_word();
    int acc, nb;
    bit to;
    do_reset();
    model_word(32'h44332211, nb);
    send_word(32'h44332211, 1'b0, acc);
    wait_drain(to);
    checks++;
    if (to || rxq.size() != expq.size()) begin
      errors++;
      $display("[TB] FAIL basic_len: got %0d bytes, want %0d", rxq.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < rxq.size(); i++) begin
      checks++;
      if (rxq[i] !== expq[i]) begin
        errors++;
        $display("[TB] FAIL basic_byte%0d: got %h, want %h", i, rxq[i], expq[i]);
      end
    end
    checks++;
    if (rxc.size() > 0 && rxc[0] != acc) begin
      errors++;
      $display("[TB] FAIL basic_latency: first byte cycle %0d, want %0d", rxc[0], acc);
    end
    for (int i = 1; i < rxc.size(); i++) begin
      checks++;
      if (rxc[i] != rxc[i-1] + 1) begin
        errors++;
        $display("[TB] FAIL basic_consecutive%0d: cycle %0d, want %0d", i, rxc[i], rxc[i-1] + 1);
      end
    end
    checks++;
    if (byte_count !== 32'd4) begin
      errors++;
      $display("[TB] FAIL basic_count: got %0d, want 4", byte_count);
    end
  endtask

  task automatic test_stuffing();
    logic [31:0] words[3] = '{32'hFF00FF12, 32'hFFFFFFFF, 32'hAABBCCDD};
    int acc, nb, total;
    bit to;
    for (int s = 0; s < 2; s++) begin
      do_reset();
      total = 0;
      for (int k = (s == 0 ? 0 : 1); k < (s == 0 ? 1 : 3); k++) begin
        model_word(words[k], nb);
        total += nb;
        send_word(words[k], 1'b0, acc);
      end
      wait_drain(to);
      checks++;
      if (to || rxq.size() != expq.size()) begin
        errors++;
        $display("[TB] FAIL stuff%0d_len: got %0d bytes, want %0d", s, rxq.size(), expq.size());
      end
      for (int i = 0; i < expq.size() && i < rxq.size(); i++) begin
        checks++;
        if (rxq[i] !== expq[i]) begin
          errors++;
          $display("[TB] FAIL stuff%0d_byte%0d: got %h, want %h", s, i, rxq[i], expq[i]);
        end
      end
      checks++;
      if (byte_count !== total) begin
        errors++;
        $display("[TB] FAIL stuff%0d_count: got %0d, want %0d", s, byte_count, total);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc, nb;
    bit to;
    do_reset();
    model_word(32'h04030201, nb);
    send_word(32'h04030201, 1'b0, acc);
    @(posedge clock);
    #1;
    byte_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++;
      if (byte_out_valid !== 1'b1 || byte_out !== 8'h02) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: got valid=%0b byte=%h, want valid=1 byte=02",
                 k, byte_out_valid, byte_out);
      end
    end
    @(posedge clock);
    #1;
    byte_out_ready = 1'b1;
    wait_drain(to);
    checks++;
    if (to || rxq.size() != expq.size()) begin
      errors++;
      $display("[TB] FAIL bp_len: got %0d bytes, want %0d", rxq.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < rxq.size(); i++) begin
      checks++;
      if (rxq[i] !== expq[i]) begin
        errors++;
        $display("[TB] FAIL bp_byte%0d: got %h, want %h", i, rxq[i], expq[i]);
      end
    end
  endtask

  task automatic test_eoi();
    int acc, nb, n;
    bit sawReady, found;
    do_reset();
    model_word(32'h000000FF, nb);
    expq.push_back(8'hFF);
    expq.push_back(8'hD9);
    send_word(32'h000000FF, 1'b1, acc);
    sawReady = 1'b0;
    found = 1'b0;
    n = 0;
    while (!found && n < 100) begin
      @(negedge clock);
      n++;
      if (eoi_done) found = 1'b1;
      else if (data_in_ready) sawReady = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL eoi_done_seen: got no pulse in %0d cycles, want one", n);
    end
    checks++;
    if (byte_count !== 32'd7) begin
      errors++;
      $display("[TB] FAIL eoi_count_final: got %0d, want 7", byte_count);
    end
    checks++;
    if (sawReady) begin
      errors++;
      $display("[TB] FAIL eoi_ready_low: got data_in_ready=1 before eoi_done, want 0");
    end
    @(negedge clock);
    checks++;
    if (eoi_done !== 1'b0 || byte_count !== 32'd0) begin
      errors++;
      $display("[TB] FAIL eoi_after: got done=%0b count=%0d, want done=0 count=0", eoi_done, byte_count);
    end
    checks++;
    if (rxq.size() != expq.size()) begin
      errors++;
      $display("[TB] FAIL eoi_len: got %0d bytes, want %0d", rxq.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < rxq.size(); i++) begin
      checks++;
      if (rxq[i] !== expq[i]) begin
        errors++;
        $display("[TB] FAIL eoi_byte%0d: got %h, want %h", i, rxq[i], expq[i]);
      end
    end
    repeat (5) @(negedge clock);
    checks++;
    if (eoiDoneCnt != 1) begin
      errors++;
      $display("[TB] FAIL eoi_pulses: got %0d, want 1", eoiDoneCnt);
    end
  endtask

  task automatic test_reset_midword();
    int acc, nb, n;
    bit to;
    do_reset();
    send_word(32'h44332211, 1'b0, acc);
    n = 0;
    while (!(byte_out_valid && byte_out == 8'h33) && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({byte_out, byte_out_valid, eoi_done, data_in_ready} !== 11'd0 || byte_count !== 32'd0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got byte=%h valid=%0b done=%0b ready=%0b count=%0d, want all 0",
               byte_out, byte_out_valid, eoi_done, data_in_ready, byte_count);
    end
    checks++;
    if (rxq.size() != 2) begin
      errors++;
      $display("[TB] FAIL midreset_prefix: got %0d bytes before reset, want 2", rxq.size());
    end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    rxq.delete();
    rxc.delete();
    expq.delete();
    model_word(32'h88776655, nb);
    send_word(32'h88776655, 1'b0, acc);
    wait_drain(to);
    checks++;
    if (to || rxq.size() != expq.size()) begin
      errors++;
      $display("[TB] FAIL midreset_len: got %0d bytes, want %0d", rxq.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < rxq.size(); i++) begin
      checks++;
      if (rxq[i] !== expq[i]) begin
        errors++;
        $display("[TB] FAIL midreset_byte%0d: got %h, want %h", i, rxq[i], expq[i]);
      end
    end
    checks++;
    if (byte_count !== 32'd4) begin
      errors++;
      $display("[TB] FAIL midreset_count: got %0d, want 4", byte_count);
    end
  endtask

  task automatic test_random();
    int acc, nb, expCount, eoiExp;
    logic [31:0] w;
    bit eoi, to;
    do_reset();
    expCount = 0;
    eoiExp = 0;
    bpRandom = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        send_eoi();
        expq.push_back(8'hFF);
        expq.push_back(8'hD9);
        expCount = 0;
        eoiExp++;
      end else begin
        for (int j = 0; j < 4; j++)
          w[8*j +: 8] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
        eoi = ($urandom_range(0, 7) == 0);
        model_word(w, nb);
        send_word(w, eoi, acc);
        if (eoi) begin
          expq.push_back(8'hFF);
          expq.push_back(8'hD9);
          expCount = 0;
          eoiExp++;
        end else begin
          expCount += nb;
        end
      end
    end
    wait_drain(to);
    bpRandom = 1'b0;
    @(posedge clock);
    #1;
    byte_out_ready = 1'b1;
    repeat (4) @(negedge clock);
    checks++;
    if (to || rxq.size() != expq.size()) begin
      errors++;
      $display("[TB] FAIL rand_len: got %0d bytes, want %0d", rxq.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < rxq.size(); i++) begin
      checks++;
      if (rxq[i] !== expq[i]) begin
        errors++;
        $display("[TB] FAIL rand_byte%0d: got %h, want %h", i, rxq[i], expq[i]);
      end
    end
    checks++;
    if (byte_count !== expCount) begin
      errors++;
      $display("[TB] FAIL rand_count: got %0d, want %0d", byte_count, expCount);
    end
    checks++;
    if (eoiDoneCnt != eoiExp) begin
      errors++;
      $display("[TB] FAIL rand_eoi_pulses: got %0d, want %0d", eoiDoneCnt, eoiExp);
    end
  endtask

  initial begin
    test_reset();
    test_basic_word();
    test_stuffing();
    test_backpressure();
    test_eoi();
    test_reset_midword();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
